// File: rtl/trace_capture_core.sv
// Logic-analyser capture engine: ring buffer with masked trigger, pre-trigger window and ready/valid readout.
// Optional build macro TRACE_CAPTURE_TIMESTAMP_EN stores a free-running 16-bit timestamp with each sample.
module trace_capture_core #(
    parameter int unsigned TRACE_W  = 6,
    parameter int unsigned TRIG_W   = 1,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned PRE_TRIG = 16,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [TRACE_W-1:0]  trace_din,
    input  logic [TRIG_W-1:0]   trigger_din,
    input  logic                trigger_en,
    input  logic [TRIG_W-1:0]   trig_mask,
    input  logic [TRIG_W-1:0]   trig_value,
    input  logic                arm,
    input  logic                abort,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    output logic [TRACE_W+16-1:0] rd_data,
`else
    output logic [TRACE_W-1:0]  rd_data,
`endif
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last,
    output logic                busy,
    output logic                triggered
);

    localparam int unsigned CW        = AW + 1;
    localparam int unsigned POST_INIT = DEPTH - PRE_TRIG - 1;
    localparam int unsigned PRE_LAST  = (PRE_TRIG == 0) ? 0 : PRE_TRIG - 1;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int unsigned TS_W      = 16;
    localparam int unsigned DW        = TRACE_W + TS_W;
`else
    localparam int unsigned DW        = TRACE_W;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_WAIT_TRIG,
        S_POST,
        S_READ
    } state_t;

    state_t          state, state_nxt;

    logic [AW-1:0]   wptr, tptr, rptr, fill, post_cnt;
    logic [CW-1:0]   fetch_cnt, out_cnt;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   mem_q, wr_word;
    logic            q_vld;
    logic            match, wr_en, trig_hit;
    logic            fetch_en, out_load, beat_acc;

    assign match = trigger_en & (&(~(trigger_din ^ trig_value) | ~trig_mask));

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    // Free-running timestamp, independent of capture state
    always_ff @(posedge clk) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + TS_W'(1);
    end

    assign wr_word = {ts, trace_din};
`else
    assign wr_word = trace_din;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state, write enable, trigger detect and busy decode
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trig_hit  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (arm) state_nxt = (PRE_TRIG == 0) ? S_WAIT_TRIG : S_PRETRIG;
            end
            S_PRETRIG: begin
                wr_en = 1'b1;
                if (fill == AW'(PRE_LAST)) state_nxt = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                wr_en = 1'b1;
                if (match) begin
                    trig_hit  = 1'b1;
                    state_nxt = (POST_INIT == 0) ? S_READ : S_POST;
                end
            end
            S_POST: begin
                wr_en = 1'b1;
                if (post_cnt == AW'(1)) state_nxt = S_READ;
            end
            S_READ: begin
                if (beat_acc && rd_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Sample storage; no reset so it maps onto a plain RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (fetch_en) mem_q <= mem[rptr];
    end

    // Two-stage read pipe: RAM output register feeds the rd_data register
    assign beat_acc = rd_valid & rd_ready;
    assign out_load = q_vld & (~rd_valid | rd_ready);
    assign fetch_en = (state == S_READ) & (fetch_cnt != CW'(DEPTH)) & (~q_vld | out_load);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr      <= '0;
            tptr      <= '0;
            rptr      <= '0;
            fill      <= '0;
            post_cnt  <= '0;
            fetch_cnt <= '0;
            out_cnt   <= '0;
            q_vld     <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            triggered <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);

            case (state)
                S_IDLE: begin
                    if (arm) begin
                        fill      <= '0;
                        triggered <= 1'b0;
                    end
                end
                S_PRETRIG:   fill <= fill + AW'(1);
                S_WAIT_TRIG: begin
                    if (trig_hit) begin
                        tptr      <= wptr;
                        triggered <= 1'b1;
                        post_cnt  <= AW'(POST_INIT);
                    end
                end
                S_POST:      post_cnt <= post_cnt - AW'(1);
                default: ;
            endcase

            // Oldest sample of the window sits PRE_TRIG entries before the trigger sample
            if (state != S_READ && state_nxt == S_READ) begin
                rptr      <= ((state == S_WAIT_TRIG) ? wptr : tptr) - AW'(PRE_TRIG);
                fetch_cnt <= '0;
                out_cnt   <= '0;
                q_vld     <= 1'b0;
            end

            if (fetch_en) begin
                rptr      <= rptr + AW'(1);
                fetch_cnt <= fetch_cnt + CW'(1);
                q_vld     <= 1'b1;
            end else if (out_load) begin
                q_vld     <= 1'b0;
            end

            if (out_load) begin
                rd_data  <= mem_q;
                rd_valid <= 1'b1;
                rd_last  <= (out_cnt == CW'(DEPTH - 1));
                out_cnt  <= out_cnt + CW'(1);
            end else if (beat_acc) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            if (abort) begin
                triggered <= 1'b0;
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
                q_vld     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_core.sv
// Scoreboard bench for trace_capture_core: directed captures, expected windows queued, monitor checks beats.
module tb_trace_capture_core;

    localparam int unsigned TRACE_W  = 6;
    localparam int unsigned TRIG_W   = 1;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned PRE_TRIG = 16;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int unsigned RDW = TRACE_W + 16;
`else
    localparam int unsigned RDW = TRACE_W;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [TRACE_W-1:0] trace_din;
    logic [TRIG_W-1:0]  trigger_din;
    logic               trigger_en;
    logic [TRIG_W-1:0]  trig_mask;
    logic [TRIG_W-1:0]  trig_value;
    logic               arm;
    logic               abort;
    logic [RDW-1:0]     rd_data;
    logic               rd_valid;
    logic               rd_ready;
    logic               rd_last;
    logic               busy;
    logic               triggered;

    typedef struct packed {
        logic [TRACE_W-1:0] data;
        logic               last;
        logic [6:0]         idx;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ready_mode = 0;

    trace_capture_core #(
        .TRACE_W (TRACE_W),
        .TRIG_W  (TRIG_W),
        .DEPTH   (DEPTH),
        .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trace_din  (trace_din),
        .trigger_din(trigger_din),
        .trigger_en (trigger_en),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .arm        (arm),
        .abort      (abort),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .busy       (busy),
        .triggered  (triggered)
    );

    always #5 clk = ~clk;

    // Consumer ready: always high, or ~30% duty random back-pressure
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks hold during stalls
    initial begin
        logic               stall_prev;
        logic [RDW-1:0]     held_data;
        logic               held_last;
        logic [15:0]        prev_ts;
        exp_t               e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        prev_ts    = '0;
        forever begin
            @(negedge clk);
            if (rd_valid && stall_prev) begin
                checks++;
                if (rd_data !== held_data || rd_last !== held_last) begin
                    failures++;
                    $display("FAIL stall_hold: data=%0h last=%0b, held data=%0h last=%0b",
                             rd_data, rd_last, held_data, held_last);
                end
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%0h last=%0b, expected no beat", rd_data, rd_last);
                end else begin
                    e = q.pop_front();
                    if (rd_data[TRACE_W-1:0] !== e.data || rd_last !== e.last) begin
                        failures++;
                        $display("FAIL beat%0d: data=%0h last=%0b, expected data=%0h last=%0b",
                                 e.idx, rd_data[TRACE_W-1:0], rd_last, e.data, e.last);
                    end
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
                    if (e.idx != 7'd0) begin
                        checks++;
                        if (rd_data[RDW-1:TRACE_W] !== prev_ts + 16'd1) begin
                            failures++;
                            $display("FAIL ts_step beat%0d: ts=%0h, expected %0h",
                                     e.idx, rd_data[RDW-1:TRACE_W], prev_ts + 16'd1);
                        end
                    end
                    prev_ts = rd_data[RDW-1:TRACE_W];
`endif
                end
            end
            stall_prev = rd_valid & ~rd_ready;
            held_data  = rd_data;
            held_last  = rd_last;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one capture; sample k carries trace value start+k, trigger expected on sample exp_trig
    task automatic capture(input string name, input int start, input int hit_k,
                           input logic msk, input logic val, input logic hit_din, input int exp_trig);
        exp_t e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e.data = TRACE_W'(start + exp_trig - int'(PRE_TRIG) + i);
            e.last = (i == int'(DEPTH) - 1);
            e.idx  = 7'(i);
            q.push_back(e);
        end
        trigger_en = 1'b1;
        trig_mask  = msk;
        trig_value = val;
        trigger_din = ~hit_din;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk({name, "_trig_clear"}, 32'(triggered), 32'd0);
        for (int k = 0; k < exp_trig + int'(DEPTH - PRE_TRIG); k++) begin
            trace_din   = TRACE_W'(start + k);
            trigger_din = (k == hit_k) ? hit_din : ~hit_din;
            tick();
        end
        trigger_din = ~hit_din;
        chk({name, "_triggered"}, 32'(triggered), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_drain: %0d beats outstanding, busy=%0b, expected 0 and 0", name, q.size(), busy);
            q.delete();
        end
        tick();
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_sticky"}, 32'(triggered), 32'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        trace_din   = '0;
        trigger_din = '0;
        trigger_en  = 1'b0;
        trig_mask   = '1;
        trig_value  = '1;
        arm         = 1'b0;
        abort       = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_last", 32'(rd_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        tick();

        // Trigger on sample 40: window samples 24..87, beat 16 is the trigger sample
        capture("t40", 0, 40, 1'b1, 1'b1, 1'b1, 40);
        wait_drain("t40");

        // Active-low pattern: trigger when trigger_din drops at sample 50
        capture("lo50", 7, 50, 1'b1, 1'b0, 1'b0, 50);
        wait_drain("lo50");

        // All-zero mask matches on the first WAIT_TRIG cycle (sample 16)
        capture("mask0", 5, -1, 1'b0, 1'b0, 1'b1, 16);
        wait_drain("mask0");

        // Random back-pressure on the readout
        ready_mode = 1;
        capture("stall", 10, 30, 1'b1, 1'b1, 1'b1, 30);
        wait_drain("stall");
        ready_mode = 0;

        // Abort during POST, then capture again
        trigger_en = 1'b1;
        trig_mask  = 1'b1;
        trig_value = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 25; k++) begin
            trace_din   = TRACE_W'(k);
            trigger_din = (k == 20);
            tick();
        end
        trigger_din = 1'b0;
        chk("abort_pre_trig", 32'(triggered), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_trig", 32'(triggered), 32'd0);
        repeat (10) tick();
        chk("abort_no_valid", 32'(rd_valid), 32'd0);
        capture("rearm", 33, 25, 1'b1, 1'b1, 1'b1, 25);
        wait_drain("rearm");

        // Abort wins over a simultaneous arm
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_busy", 32'(busy), 32'd0);

        // Matching pattern with trigger_en low never fires
        trigger_en  = 1'b0;
        trigger_din = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (120) tick();
        chk("tren0_busy", 32'(busy), 32'd1);
        chk("tren0_trig", 32'(triggered), 32'd0);
        chk("tren0_valid", 32'(rd_valid), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("tren0_abort", 32'(busy), 32'd0);
        trigger_din = 1'b0;

        // Synchronous reset in the middle of readout
        capture("rstrd", 0, 20, 1'b1, 1'b1, 1'b1, 20);
        begin
            int n;
            n = 0;
            while (q.size() > 54 && n < 500) begin
                tick();
                n++;
            end
            chk("rstrd_progress", 32'(n < 500), 32'd1);
        end
        reset_n = 1'b0;
        tick();
        q.delete();
        chk("rstrd_valid", 32'(rd_valid), 32'd0);
        chk("rstrd_busy", 32'(busy), 32'd0);
        chk("rstrd_trig", 32'(triggered), 32'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rstrd_quiet", 32'(rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
